seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed driver for a bank of common-anode-select 7-segment digits. Takes a packed BCD word and per-digit decimal points and holds them in a snapshot register. It then scans one digit at a time at a programmable rate, with leading-zero blanking, per-digit blink, and a dash glyph for non-decimal codes. It sits between the arithmetic result path (BCD converter) and the board pins, and replaces static per-digit decoding wherever the digit selects are shared.

## Interface
Parameters:
- DIGITS, 4, number of digits scanned (≥2)
- SCAN_DIV, 50000, clock cycles each digit stays selected (≥2)
- BLINK_FRAMES, 64, full scan frames per blink half-period (≥1)

Ports:
- clk  in  1  system clock; one clock domain
- rst_n  in  1  reset, asynchronous assert, active-low
- en  in  1  display enable
- load  in  1  capture bcd/dp into snapshot this cycle
- bcd  in  DIGITS*4  packed BCD, digit i at [i*4+:4], digit 0 rightmost
- dp  in  DIGITS  decimal point per digit
- blank_lz  in  1  enable leading-zero blanking
- blink_mask  in  DIGITS  digits that blink
- an  out  DIGITS  digit select, active-low one-hot; all ones = dark
- seg  out  8  segments {a,b,c,d,e,f,g,dp}, active-high, registered

## Operation
- Snapshot: when load=1, bcd and dp are registered the same edge. The display uses only the snapshot. Changes to bcd without load are invisible.
- Scan: a divider counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and the digit index advances (DIGITS-1 wraps to 0). A frame ends when the index wraps.
- Glyphs: 0..9 use the standard codes (0 = 11111100, 1 = 01100000, 2 = 11011010, 3 = 11110010, 4 = 01100110, 5 = 10110110, 6 = 10111110, 7 = 11100000, 8 = 11111110, 9 = 11110110). Codes 10..15 show a dash (00000010). The dp bit ORs into bit 0.
- Leading-zero blanking (blank_lz=1): starting from digit DIGITS-1, each consecutive digit whose code is 0 and whose dp is 0 is blanked (seg=0), stopping at the first digit that fails either test. Digit 0 is never blanked by this rule.
- Blink: a frame counter counts 0..BLINK_FRAMES-1 and toggles blink_phase at wrap. While blink_phase=1, digits with blink_mask set show seg=0; an still selects them.
- en=0: the divider, index and frame counter clear to 0 and blink_phase clears. Outputs go dark: an all ones, seg=0.
- Reset value of every output and register: an = all ones, seg = 0, index = 0, divider = 0, frame counter = 0, blink_phase = 0, snapshot = 0.

## Timing
- an and seg are registered from the current index, snapshot and blink_phase. They reflect state one clock after it changes.
- After en rises, the first edge presents digit 0. Each digit then holds for exactly SCAN_DIV cycles.
- A load takes effect on the displayed digit one clock after the capture edge. No partial-frame restart occurs.
- Simultaneous load and index advance: the new snapshot and new index appear together on the next edge.
- A blink toggle coincides with the index wrap, so the phase is constant within a frame.
- rst_n low mid-frame forces all reset values immediately, without waiting for a clock edge. On release, the block restarts at digit 0.

## Structure
- Shared package seg_pkg holds:
  - SEG_0..SEG_9, SEG_DASH and SEG_OFF constants
  - segment bit-position constants (SEG_A..SEG_DP)
- One combinational sub-module, seg_glyph, maps a 4-bit code plus dp to 8 segments. The top instantiates one and muxes its input by index.
- The leading-zero mask is computed combinationally from the snapshot, as a DIGITS-bit vector.

## Test plan
Configuration: DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2 unless stated.
- Reset, then en=1 with snapshot 0 -> an=1111, seg=0 during reset; one clock after en: an=1110, seg=11111100, held 4 cycles.
- load with bcd=16'h1234, dp=0 -> an 1110/seg 01100110, then 1101/11110010, then 1011/11011010, then 0111/01100000, each for 4 cycles, then wraps to 1110.
- blank_lz=1, bcd=16'h0050 -> digits 3 and 2 seg=0, digit 1 10110110, digit 0 11111100. bcd=16'h0000 -> only digit 0 lit. bcd=16'h0050 with dp=4'b0100 -> digit 2 shows 11111101.
- bcd=16'h00AF, blank_lz=0 -> digits 0 and 1 show 00000010; digits 2 and 3 show 11111100.
- blink_mask=4'b0001, bcd=16'h1234 -> digit 0 shows 01100110 in frames 0-1 and 0 in frames 2-3 (an still 1110), repeating. Other digits are unaffected.
- bcd changed without load -> display unchanged. rst_n pulsed low mid-digit-2 -> an=1111 and seg=0 asynchronously, then restart at digit 0 with snapshot 0.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the 7-segment scan controller.
//   Segment bit positions inside the 8-bit seg bus {a,b,c,d,e,f,g,dp}
//   (a is bit 7, dp is bit 0) and the glyph codes used by seg_glyph.
package seg_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [7:0] SEG_0    = 8'b1111_1100;
  localparam logic [7:0] SEG_1    = 8'b0110_0000;
  localparam logic [7:0] SEG_2    = 8'b1101_1010;
  localparam logic [7:0] SEG_3    = 8'b1111_0010;
  localparam logic [7:0] SEG_4    = 8'b0110_0110;
  localparam logic [7:0] SEG_5    = 8'b1011_0110;
  localparam logic [7:0] SEG_6    = 8'b1011_1110;
  localparam logic [7:0] SEG_7    = 8'b1110_0000;
  localparam logic [7:0] SEG_8    = 8'b1111_1110;
  localparam logic [7:0] SEG_9    = 8'b1111_0110;
  localparam logic [7:0] SEG_DASH = 8'b0000_0010;
  localparam logic [7:0] SEG_OFF  = 8'b0000_0000;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: display-side bundle of the scan controller.
//   en, load, bcd, dp, blank_lz, blink_mask : driven by the master (data source)
//   an, seg                                 : driven by the slave (scan controller)
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  load;
  logic [DIGITS*4-1:0]   bcd;
  logic [DIGITS-1:0]     dp;
  logic                  blank_lz;
  logic [DIGITS-1:0]     blink_mask;
  logic [DIGITS-1:0]     an;
  logic [7:0]            seg;

  modport master (
    output en, load, bcd, dp, blank_lz, blink_mask,
    input  an, seg
  );

  modport slave (
    input  en, load, bcd, dp, blank_lz, blink_mask,
    output an, seg
  );
endinterface

// File: rtl/seg_glyph.sv
// seg_glyph: combinational BCD-to-7-segment decoder.
//   code [3:0] : digit code; 10..15 render as a dash
//   dp         : decimal point, ORed into seg[SEG_DP]
//   seg  [7:0] : active-high segments {a,b,c,d,e,f,g,dp}
module seg_glyph
  import seg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] base;

  always_comb begin
    base = SEG_DASH;
    case (code)
      4'd0:    base = SEG_0;
      4'd1:    base = SEG_1;
      4'd2:    base = SEG_2;
      4'd3:    base = SEG_3;
      4'd4:    base = SEG_4;
      4'd5:    base = SEG_5;
      4'd6:    base = SEG_6;
      4'd7:    base = SEG_7;
      4'd8:    base = SEG_8;
      4'd9:    base = SEG_9;
      default: base = SEG_DASH;
    endcase
    seg         = base;
    seg[SEG_DP] = base[SEG_DP] | dp;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed driver for a bank of 7-segment digits.
//   clk, rst_n : clock and async active-low reset
//   bus.slave  : en, load, bcd, dp, blank_lz, blink_mask in; an (active-low
//                one-hot digit select), seg (active-high segments) out
// The display works only from a snapshot of bcd/dp captured on load. One
// digit is selected for SCAN_DIV cycles at a time; the blink phase flips
// every BLINK_FRAMES full frames, always on the index wrap.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_scan_ctrl_if.slave bus
);

  localparam int IW = $clog2(DIGITS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DW-1:0]        div;
  logic [IW-1:0]        idx;
  logic [FW-1:0]        frame_cnt;
  logic                 blink_phase;
  logic [DIGITS*4-1:0]  snap_bcd;
  logic [DIGITS-1:0]    snap_dp;
  logic [DIGITS-1:0]    lz_mask;
  logic                 lz_run;
  logic [3:0]           cur_code;
  logic                 cur_dp;
  logic [7:0]           glyph;
  logic                 div_tc;
  logic                 idx_last;

  assign div_tc   = (div == DW'(SCAN_DIV - 1));
  assign idx_last = (idx == IW'(DIGITS - 1));

  // Leading zeros: walk down from the top digit while code==0 and dp==0.
  // Digit 0 is always shown, so the walk stops at digit 1.
  always_comb begin
    lz_mask = '0;
    lz_run  = bus.blank_lz;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run     = lz_run && (snap_bcd[i*4 +: 4] == 4'd0) && !snap_dp[i];
      lz_mask[i] = lz_run;
    end
  end

  assign cur_code = snap_bcd[int'(idx)*4 +: 4];
  assign cur_dp   = snap_dp[idx];

  seg_glyph u_glyph (
    .code (cur_code),
    .dp   (cur_dp),
    .seg  (glyph)
  );

  // Snapshot is independent of en so a value can be staged while dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_bcd <= '0;
      snap_dp  <= '0;
    end else if (bus.load) begin
      snap_bcd <= bus.bcd;
      snap_dp  <= bus.dp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div         <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!bus.en) begin
      div         <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (div_tc) begin
        div <= '0;
        idx <= idx_last ? '0 : idx + IW'(1);
      end else begin
        div <= div + DW'(1);
      end
      // Counting frames on the index wrap keeps the phase constant in a frame.
      if (div_tc && idx_last) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.an  <= '1;
      bus.seg <= SEG_OFF;
    end else if (!bus.en) begin
      bus.an  <= '1;
      bus.seg <= SEG_OFF;
    end else begin
      bus.an  <= ~(DIGITS'(1) << idx);
      bus.seg <= (lz_mask[idx] || (blink_phase && bus.blink_mask[idx])) ? SEG_OFF : glyph;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl (DIGITS=4,
// SCAN_DIV=4, BLINK_FRAMES=2). Stimulus pushes the expected an/seg for
// each future cycle number; a negedge monitor pops and compares.
module tb_seg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int SDIV   = 4;
  localparam int FRAME  = DIGITS * SDIV;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [7:0] seg;
    string      name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   t0;
  int   n_checks;
  int   n_fail;
  exp_t q[$];
  logic [3:0] an_of [4];

  seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_ctrl #(
    .DIGITS       (DIGITS),
    .SCAN_DIV     (SDIV),
    .BLINK_FRAMES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every entry whose cycle has come up.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_checks++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: entry for cycle %0d was never sampled (now %0d)", e.name, e.cyc, cyc);
      end else if (bus.an !== e.an || bus.seg !== e.seg) begin
        n_fail++;
        $display("FAIL %s cyc %0d: got an=%b seg=%b, expected an=%b seg=%b",
                 e.name, cyc, bus.an, bus.seg, e.an, e.seg);
      end
    end
  end

  task automatic push(input int c, input logic [3:0] a, input logic [7:0] s, input string nm);
    exp_t e;
    e.cyc  = c;
    e.an   = a;
    e.seg  = s;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic push_frames(input int f, input int n,
                             input logic [7:0] s3, input logic [7:0] s2,
                             input logic [7:0] s1, input logic [7:0] s0,
                             input string nm);
    logic [7:0] s [4];
    s = '{s0, s1, s2, s3};
    for (int j = 0; j < n; j++)
      for (int d = 0; d < DIGITS; d++)
        for (int k = 0; k < SDIV; k++)
          push(f + FRAME*j + SDIV*d + k, an_of[d], s[d], nm);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // First frame start that is clear of any input change made this cycle.
  function automatic int next_frame();
    int d;
    d = cyc + 2 - t0;
    return t0 + ((d + FRAME - 1) / FRAME) * FRAME;
  endfunction

  task automatic do_load(input logic [15:0] b, input logic [3:0] p);
    bus.load = 1'b1;
    bus.bcd  = b;
    bus.dp   = p;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  initial begin
    int f;
    int k;
    int x;
    an_of = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    n_checks = 0;
    n_fail   = 0;
    t0       = 0;
    rst_n          = 1'b0;
    bus.en         = 1'b0;
    bus.load       = 1'b0;
    bus.bcd        = '0;
    bus.dp         = '0;
    bus.blank_lz   = 1'b0;
    bus.blink_mask = '0;

    // Reset, then enable with an all-zero snapshot.
    for (int c = 1; c <= 3; c++) push(c, 4'b1111, 8'h00, "reset_dark");
    wait_cyc(3);
    rst_n = 1'b1;
    push(4, 4'b1111, 8'h00, "en_low_dark");
    push(5, 4'b1111, 8'h00, "en_low_dark");
    wait_cyc(5);
    bus.en = 1'b1;
    t0 = 6;
    push_frames(t0, 1, 8'b11111100, 8'b11111100, 8'b11111100, 8'b11111100, "first_frame_zero");
    wait_cyc(t0 + FRAME - 1);

    // 1234, two frames to cover the wrap back to digit 0.
    do_load(16'h1234, 4'b0000);
    f = next_frame();
    push_frames(f, 2, 8'b01100000, 8'b11011010, 8'b11110010, 8'b01100110, "scan_1234");
    wait_cyc(f + 2*FRAME - 1);

    // Leading-zero blanking.
    bus.blank_lz = 1'b1;
    do_load(16'h0050, 4'b0000);
    f = next_frame();
    push_frames(f, 1, 8'h00, 8'h00, 8'b10110110, 8'b11111100, "lz_0050");
    wait_cyc(f + FRAME - 1);

    do_load(16'h0000, 4'b0000);
    f = next_frame();
    push_frames(f, 1, 8'h00, 8'h00, 8'h00, 8'b11111100, "lz_0000");
    wait_cyc(f + FRAME - 1);

    do_load(16'h0050, 4'b0100);
    f = next_frame();
    push_frames(f, 1, 8'h00, 8'b11111101, 8'b10110110, 8'b11111100, "lz_dp_stops");
    wait_cyc(f + FRAME - 1);

    // Non-decimal codes render as a dash.
    bus.blank_lz = 1'b0;
    do_load(16'h00AF, 4'b0000);
    f = next_frame();
    push_frames(f, 1, 8'b11111100, 8'b11111100, 8'b00000010, 8'b00000010, "dash_00af");
    wait_cyc(f + FRAME - 1);

    // Blink on digit 0: phase = (frames since enable / 2) mod 2.
    bus.blink_mask = 4'b0001;
    do_load(16'h1234, 4'b0000);
    f = next_frame();
    for (int j = 0; j < 4; j++) begin
      k = (f - t0) / FRAME + j;
      push_frames(f + FRAME*j, 1, 8'b01100000, 8'b11011010, 8'b11110010,
                  ((k / 2) % 2 == 1) ? 8'h00 : 8'b01100110, "blink_d0");
    end
    wait_cyc(f + 4*FRAME - 1);

    // bcd change without load stays invisible.
    bus.blink_mask = 4'b0000;
    bus.bcd        = 16'h9999;
    bus.dp         = 4'b1111;
    @(negedge clk);
    f = next_frame();
    push_frames(f, 1, 8'b01100000, 8'b11011010, 8'b11110010, 8'b01100110, "no_load_hold");
    wait_cyc(f + FRAME - 1);

    // en drop clears scan and blink state; restart at digit 0.
    bus.blink_mask = 4'b0001;
    x = cyc;
    bus.en = 1'b0;
    push(x + 1, 4'b1111, 8'h00, "en_drop_dark");
    push(x + 2, 4'b1111, 8'h00, "en_drop_dark");
    wait_cyc(x + 2);
    bus.en = 1'b1;
    t0 = x + 3;
    push_frames(t0, 1, 8'b01100000, 8'b11011010, 8'b11110010, 8'b01100110, "en_restart");
    wait_cyc(t0 + FRAME - 1);
    bus.blink_mask = 4'b0000;

    // Async reset in the middle of digit 2.
    @(negedge clk);
    f = next_frame();
    push(f + 8, 4'b1011, 8'b11011010, "pre_reset_d2");
    push(f + 9, 4'b1011, 8'b11011010, "pre_reset_d2");
    wait_cyc(f + 9);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    push(f + 10, 4'b1111, 8'h00, "async_reset_dark");
    push(f + 11, 4'b1111, 8'h00, "async_reset_dark");
    wait_cyc(f + 11);
    rst_n = 1'b1;
    t0 = f + 12;
    push_frames(t0, 1, 8'b11111100, 8'b11111100, 8'b11111100, 8'b11111100, "post_reset_zero");

    // Drain with a bounded wait.
    for (int c = 0; c < 200 && q.size() > 0; c++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
